// File: rtl/vec_pkg.sv
// Vector load/store unit shared definitions.
// Lane geometry, legal vector register window and FSM encoding.
package vec_pkg;

  localparam int LANES  = 8;
  localparam int LANE_W = 32;
  localparam int VLEN   = LANES * LANE_W;
  localparam int CNT_W  = $clog2(LANES);

  localparam logic [4:0] VREG_FIRST = 5'd16;
  localparam logic [4:0] VREG_LAST  = 5'd23;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STORE,
    WB,
    FIN
  } state_t;

  typedef logic [LANES-1:0][LANE_W-1:0] vec_t;

  function automatic logic [31:0] lane_addr(
    input logic [31:0]      base,
    input logic [CNT_W-1:0] k
  );
    return base + {{(30-CNT_W){1'b0}}, k, 2'b00};
  endfunction

endpackage

// File: rtl/vec_lsu_if.sv
// Command, data-memory and vector-regfile bus of the vector LSU.
// master drives commands and read data; slave is the LSU itself.
interface vec_lsu_if;
  import vec_pkg::*;

  logic              start;
  logic              is_store;
  logic [31:0]       base_addr;
  logic [4:0]        vreg;
  logic [VLEN-1:0]   vsrc;

  logic [31:0]       mem_addr;
  logic              mem_we;
  logic [LANE_W-1:0] mem_wd;
  logic [LANE_W-1:0] mem_rd;

  logic              vwe3;
  logic [4:0]        vwa3;
  logic [VLEN-1:0]   vwd3;

  logic              busy;
  logic              done;

  modport master (
    output start, is_store, base_addr,
    output vreg, vsrc, mem_rd,
    input  mem_addr, mem_we, mem_wd,
    input  vwe3, vwa3, vwd3,
    input  busy, done
  );

  modport slave (
    input  start, is_store, base_addr,
    input  vreg, vsrc, mem_rd,
    output mem_addr, mem_we, mem_wd,
    output vwe3, vwa3, vwd3,
    output busy, done
  );

endinterface

// File: rtl/vec_lsu.sv
// Vector load/store unit: one 32-bit lane per cycle,
// gather into a buffer for loads, scatter latched data for stores.
module vec_lsu
  import vec_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  vec_lsu_if.slave  bus
);

  state_t           state;
  state_t           nstate;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      base_q;
  logic [4:0]       vreg_q;
  vec_t             vsrc_q;
  vec_t             gbuf;
  logic             last;
  logic             accept;
  logic             vreg_ok;

  assign last    = (cnt == CNT_W'(LANES - 1));
  assign accept  = (state == IDLE) && bus.start;
  assign vreg_ok = (vreg_q >= VREG_FIRST) &&
                   (vreg_q <= VREG_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  // Next-state logic: lane sweep, then a one-cycle finish state.
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (bus.start)
               nstate = bus.is_store ? STORE : LOAD;
      LOAD:  if (last) nstate = WB;
      STORE: if (last) nstate = FIN;
      WB:    nstate = IDLE;
      FIN:   nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Command latch, lane counter and load gather buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      base_q <= '0;
      vreg_q <= '0;
      vsrc_q <= '0;
      gbuf   <= '0;
    end else begin
      if (accept) begin
        cnt    <= '0;
        base_q <= {bus.base_addr[31:2], 2'b00};
        vreg_q <= bus.vreg;
        vsrc_q <= bus.vsrc;
      end else if (state == LOAD || state == STORE) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == LOAD) gbuf[cnt] <= bus.mem_rd;
    end
  end

  // Outputs: everything idles at zero outside its own state.
  always_comb begin
    bus.mem_addr = '0;
    bus.mem_we   = 1'b0;
    bus.mem_wd   = '0;
    bus.vwe3     = 1'b0;
    bus.vwa3     = '0;
    bus.vwd3     = '0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (state)
      IDLE: ;
      LOAD: begin
        bus.busy     = 1'b1;
        bus.mem_addr = lane_addr(base_q, cnt);
      end
      STORE: begin
        bus.busy     = 1'b1;
        bus.mem_addr = lane_addr(base_q, cnt);
        bus.mem_we   = 1'b1;
        bus.mem_wd   = vsrc_q[cnt];
      end
      WB: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
        bus.vwe3 = vreg_ok;
        bus.vwa3 = vreg_q;
        bus.vwd3 = gbuf;
      end
      FIN: begin
        bus.busy = 1'b1;
        bus.done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vec_lsu.sv
// Randomized bench for vec_lsu against a word-addressed memory
// model and a per-cycle expectation of the lane sweep.
module tb_vec_lsu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  logic [31:0] mem [logic [31:0]];

  vec_lsu_if bus();

  vec_lsu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
  endfunction

  task automatic chk(input string tag,
                     input logic [255:0] got,
                     input logic [255:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_cmd(input bit          st,
                         input logic [31:0] base,
                         input logic [4:0]  vreg,
                         input logic [255:0] vsrc,
                         input int          abort_at,
                         input bit          perturb,
                         input bit          poke);
    logic [31:0]  b;
    logic [31:0]  a;
    logic [255:0] ev;
    logic         ok;
    b  = {base[31:2], 2'b00};
    ok = (vreg >= 5'd16) && (vreg <= 5'd23);
    ev = '0;
    for (int k = 0; k < 8; k++)
      ev[32*k +: 32] = rd(b + 32'(4*k));
    bus.start     = 1'b1;
    bus.is_store  = st;
    bus.base_addr = base;
    bus.vreg      = vreg;
    bus.vsrc      = vsrc;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      bus.mem_rd = rd(bus.mem_addr);
      if (c == 1) bus.start = 1'b0;
      if (c <= 8) begin
        a = b + 32'(4*(c-1));
        chk("lane_busy", 256'(bus.busy), 256'(1));
        chk("lane_we", 256'(bus.mem_we), 256'(st));
        chk("lane_addr", 256'(bus.mem_addr), 256'(a));
        chk("lane_wd", 256'(bus.mem_wd),
            st ? 256'(vsrc[32*(c-1) +: 32]) : 256'(0));
        chk("lane_done", 256'(bus.done), 256'(0));
        chk("lane_vwe3", 256'(bus.vwe3), 256'(0));
        if (st) mem[a] = vsrc[32*(c-1) +: 32];
      end else if (c == 9) begin
        chk("fin_done", 256'(bus.done), 256'(1));
        chk("fin_busy", 256'(bus.busy), 256'(1));
        chk("fin_we", 256'(bus.mem_we), 256'(0));
        chk("fin_vwe3", 256'(bus.vwe3), st ? 256'(0) : 256'(ok));
        chk("fin_vwa3", 256'(bus.vwa3), st ? 256'(0) : 256'(vreg));
        chk("fin_vwd3", bus.vwd3, st ? 256'(0) : ev);
      end else begin
        chk("idle_busy", 256'(bus.busy), 256'(0));
        chk("idle_done", 256'(bus.done), 256'(0));
        chk("idle_addr", 256'(bus.mem_addr), 256'(0));
      end
      if (c == 2 && perturb) begin
        bus.vsrc      = ~vsrc;
        bus.base_addr = base ^ 32'h0000_0F00;
        bus.vreg      = vreg ^ 5'h0A;
      end
      if (c == 3 && poke) begin
        bus.start     = 1'b1;
        bus.is_store  = ~st;
        bus.base_addr = 32'h0000_7000;
      end
      if (c == 4 && poke) bus.start = 1'b0;
      if (c == abort_at) begin
        rst = 1'b1;
        @(negedge clk);
        bus.mem_rd = rd(bus.mem_addr);
        chk("abort_we", 256'(bus.mem_we), 256'(0));
        chk("abort_busy", 256'(bus.busy), 256'(0));
        chk("abort_done", 256'(bus.done), 256'(0));
        chk("abort_vwe3", 256'(bus.vwe3), 256'(0));
        rst = 1'b0;
        return;
      end
    end
  endtask

  function automatic logic [255:0] rvec();
    logic [255:0] v;
    for (int k = 0; k < 8; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  initial begin
    logic [255:0] v;
    logic [31:0]  bs;
    int           sel;
    bus.start     = 1'b1;
    bus.is_store  = 1'b0;
    bus.base_addr = 32'h100;
    bus.vreg      = 5'd17;
    bus.vsrc      = '0;
    bus.mem_rd    = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 256'(bus.busy), 256'(0));
    chk("rst_we", 256'(bus.mem_we), 256'(0));
    chk("rst_done", 256'(bus.done), 256'(0));
    chk("rst_addr", 256'(bus.mem_addr), 256'(0));
    chk("rst_vwd3", bus.vwd3, 256'(0));
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    for (int k = 0; k < 8; k++)
      mem[32'h100 + 32'(4*k)] = 32'h11111111 * 32'(k+1);
    run_cmd(1'b0, 32'h100, 5'd17, '0, 0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) v[32*k +: 32] = 32'hA0 + 32'(k);
    run_cmd(1'b1, 32'h203, 5'd0, v, 0, 1'b1, 1'b0);
    run_cmd(1'b0, 32'h200, 5'd20, '0, 0, 1'b0, 1'b0);

    run_cmd(1'b0, 32'hFFFFFFF8, 5'd16, '0, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h300, 5'd3, '0, 0, 1'b0, 1'b0);
    run_cmd(1'b0, 32'h400, 5'd23, '0, 0, 1'b0, 1'b1);
    run_cmd(1'b1, 32'h500, 5'd0, rvec(), 4, 1'b0, 1'b1);
    run_cmd(1'b0, 32'h500, 5'd18, '0, 0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 2);
      bs  = (sel == 0) ? 32'h1000 + ($urandom & 32'h3F) :
            (sel == 1) ? 32'hFFFFFFF0 + ($urandom & 32'h7) :
                         $urandom;
      run_cmd(1'($urandom), bs, 5'($urandom), rvec(),
              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8) : 0,
              1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
